sd_block_read: RTL
==================

// Module: sd_block_read
// PURPOSE
// SPI-mode SD card single-block reader (CMD17), the read-side counterpart to the SD block writer.
// Runs after card initialisation completes: issues CMD17, polls R1, waits for the start-block token,
// streams the data block out one byte at a time, then captures the 16-bit CRC.
// Sits between the SD init controller (which owns the SPI pins until init_done) and consumer logic.
// PARAMETERS
// CLK_DIV        4     sclk period in clk cycles; even, >=2; sclk high/low each CLK_DIV/2 cycles
// BLOCK_BYTES    512   data bytes per block
// RESP_TIMEOUT   16    max bytes polled for R1 before abort
// TOKEN_TIMEOUT  4096  max bytes polled for the start-block token before abort
// PORTS
// clk         in   1   system clock
// reset       in   1   synchronous, active-high
// init_done   in   1   card initialised and in SPI mode; start is ignored while low
// start       in   1   one-cycle request; accepted only when busy=0 and init_done=1
// block_addr  in   32  CMD17 argument, sent unmodified (block number for SDHC, byte address for SDSC)
// busy        out  1   high from the cycle after start is accepted until done
// done        out  1   one-cycle pulse at end of transfer (success or error)
// error       out  1   valid with done; held until the next accepted start
// err_code    out  2   0 = R1 timeout, 1 = R1 nonzero, 2 = data error token, 3 = token timeout
// data_out    out  8   received data byte
// data_valid  out  1   one-cycle strobe per data byte; exactly BLOCK_BYTES strobes on success
// crc_out     out  16  received block CRC, valid at done when error=0 (not checked)
// sclk        out  1   SPI clock, idle low (mode 0)
// cs_n        out  1   chip select, active low
// mosi        out  1   SPI data to card, idle high
// miso        in   1   SPI data from card
// BEHAVIOUR
// - Reset values: busy=0, done=0, error=0, err_code=0, data_out=0, data_valid=0, crc_out=0,
//   sclk=0, cs_n=1, mosi=1; FSM returns to IDLE.
// - Byte engine: MSB first, 8 sclk periods per byte. mosi changes while sclk is low; miso is sampled
//   on each sclk rising edge. Byte completion is reported at the end of the 8th low half.
// - FSM states: IDLE -> PRE -> CMD -> R1 -> TOKEN -> DATA -> CRC -> TAIL -> IDLE.
// - PRE: cs_n low one cycle after start is accepted; 1 byte of 0xFF is sent.
// - CMD: send the 6 bytes 0x51, block_addr[31:24], [23:16], [15:8], [7:0], 0xFF.
//   block_addr is latched at start.
// - R1: send 0xFF and read bytes.
//   - 0xFF: keep polling.
//   - First non-0xFF byte equal to 0x00: go to TOKEN.
//   - First non-0xFF byte nonzero: abort with code 1.
//   - RESP_TIMEOUT bytes with no response: abort with code 0.
// - TOKEN: send 0xFF and read bytes.
//   - 0xFF: keep polling.
//   - 0xFE: go to DATA.
//   - Any other byte (pattern 000x_xxxx): abort with code 2.
//   - TOKEN_TIMEOUT bytes: abort with code 3.
// - DATA: for each of BLOCK_BYTES bytes, data_out is updated and data_valid=1 in the same single
//   cycle, at that byte's completion. No backpressure; the consumer must accept every strobe.
// - CRC: read 2 bytes into crc_out[15:8] then crc_out[7:0].
// - TAIL: cs_n high, one 0xFF byte (8 sclk periods), then done=1 for one cycle with error=0; busy
//   drops in the same cycle.
// - Abort: go to TAIL with error=1 and err_code set; no further data_valid.
// - Counters: byte counters are wide enough for max(BLOCK_BYTES, TOKEN_TIMEOUT); no wrap inside a transfer.
// - start while busy is ignored with no side effects. A start on the done cycle is ignored; start is
//   accepted from the following cycle.
// - Reset mid-operation: the next cycle shows reset values (cs_n=1, sclk=0) and there is no partial
//   byte output.
// TESTING
// 1. CLK_DIV=4, addr 0x00000004. Card model replies R1=0x00 after 2 bytes of 0xFF, then 0xFE after
//    10 bytes, data byte i = i&0xFF, CRC 0xBEEF.
//    -> mosi bytes 51 00 00 00 04 FF; 512 strobes with values 00..FF,00..FF; crc_out=0xBEEF;
//       done with error=0.
// 2. Card returns R1=0x04 -> done, error=1, err_code=1, zero data_valid, cs_n=1 afterwards.
// 3. miso held 1 -> done after 16 R1 polls, err_code=0; data token 0x09 instead -> err_code=2.
// 4. Token never sent (all 0xFF) -> err_code=3 after 4096 polled bytes.
// 5. start pulsed while busy, and while init_done=0 -> ignored. Measured sclk period is 4 clk cycles
//    and sclk idles low.
// 6. reset asserted at data byte 100 -> next cycle cs_n=1, sclk=0, busy=0, no more strobes; a new
//    start completes normally.

Source files
------------

// File: rtl/sd_block_read.sv
// SPI-mode SD card single-block reader: CMD17, R1 poll, start token, data stream, CRC capture.
// A free-running byte engine shifts back-to-back bytes; the FSM steers it at byte boundaries.
module sd_block_read #(
    parameter int CLK_DIV       = 4,
    parameter int BLOCK_BYTES   = 512,
    parameter int RESP_TIMEOUT  = 16,
    parameter int TOKEN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done_i,
    input  logic        start_i,
    input  logic [31:0] block_addr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  data_out_o,
    output logic        data_valid_o,
    output logic [15:0] crc_out_o,
    output logic        sclk_o,
    output logic        cs_n_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam int HALF = CLK_DIV / 2;
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int M1   = (BLOCK_BYTES > TOKEN_TIMEOUT) ? BLOCK_BYTES : TOKEN_TIMEOUT;
    localparam int M2   = (M1 > RESP_TIMEOUT) ? M1 : RESP_TIMEOUT;
    localparam int MAXC = (M2 > 8) ? M2 : 8;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_R1,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_TAIL
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;
    logic [CW-1:0] idx_inc;

    logic          run_q;
    logic [HW-1:0] cnt_q;
    logic [3:0]    ph_q;
    logic          sclk_q;
    logic          cs_n_q;
    logic [7:0]    tx_q;
    logic [6:0]    rx_q;
    logic [31:0]   addr_q;
    logic          done_q;
    logic          error_q;
    logic [1:0]    err_code_q;
    logic [7:0]    data_out_q;
    logic          data_valid_q;
    logic [15:0]   crc_q;

    logic          tick;
    logic          byte_done;
    logic          byte_end;
    logic [7:0]    rx_byte;
    logic          start_ok;
    logic          abort;
    logic [1:0]    abort_code;
    logic          fin;
    logic [7:0]    tx_next;
    logic          dv_set;
    logic          crc_hi_we;
    logic          crc_lo_we;

    // Each byte is 16 half-periods: even = sclk low, odd = sclk high.
    assign tick      = run_q && (cnt_q == HW'(HALF - 1));
    assign byte_done = tick && (ph_q == 4'd14);
    assign byte_end  = tick && (ph_q == 4'd15);
    assign rx_byte   = {rx_q, miso_i};
    assign idx_inc   = idx_q + 1'b1;
    assign start_ok  = start_i && init_done_i && (state_q == S_IDLE) && !done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        abort      = 1'b0;
        abort_code = 2'd0;
        fin        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_PRE;
                    idx_d   = '0;
                end
            end
            S_PRE: begin
                if (byte_done) begin
                    state_d = S_CMD;
                    idx_d   = '0;
                end
            end
            S_CMD: begin
                if (byte_done) begin
                    if (idx_q == CW'(5)) begin
                        state_d = S_R1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_R1: begin
                if (byte_done) begin
                    if (rx_byte == 8'hFF) begin
                        if (idx_inc == CW'(RESP_TIMEOUT)) begin
                            abort      = 1'b1;
                            abort_code = 2'd0;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end else if (rx_byte == 8'h00) begin
                        state_d = S_TOKEN;
                        idx_d   = '0;
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'd1;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_done) begin
                    if (rx_byte == 8'hFF) begin
                        if (idx_inc == CW'(TOKEN_TIMEOUT)) begin
                            abort      = 1'b1;
                            abort_code = 2'd3;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end else if (rx_byte == 8'hFE) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        abort      = 1'b1;
                        abort_code = 2'd2;
                    end
                end
            end
            S_DATA: begin
                if (byte_done) begin
                    if (idx_q == CW'(BLOCK_BYTES - 1)) begin
                        state_d = S_CRC;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_CRC: begin
                if (byte_done) begin
                    if (idx_q == CW'(1)) begin
                        state_d = S_TAIL;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end
            S_TAIL: begin
                // idx marks that the trailing 0xFF byte itself has been clocked.
                if (byte_done) begin
                    idx_d = CW'(1);
                end
                if (byte_end && (idx_q == CW'(1))) begin
                    fin     = 1'b1;
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
        if (abort) begin
            state_d = S_TAIL;
            idx_d   = '0;
        end
    end

    always_comb begin
        tx_next   = 8'hFF;
        dv_set    = byte_done && (state_q == S_DATA);
        crc_hi_we = byte_done && (state_q == S_CRC) && (idx_q == '0);
        crc_lo_we = byte_done && (state_q == S_CRC) && (idx_q == CW'(1));
        if (state_q == S_CMD) begin
            unique case (idx_q[2:0])
                3'd0:    tx_next = 8'h51;
                3'd1:    tx_next = addr_q[31:24];
                3'd2:    tx_next = addr_q[23:16];
                3'd3:    tx_next = addr_q[15:8];
                3'd4:    tx_next = addr_q[7:0];
                default: tx_next = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q        <= 1'b0;
            cnt_q        <= '0;
            ph_q         <= '0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            tx_q         <= 8'hFF;
            rx_q         <= '0;
            addr_q       <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            crc_q        <= '0;
        end else begin
            done_q       <= fin;
            data_valid_q <= 1'b0;
            if (start_ok) begin
                run_q      <= 1'b1;
                cnt_q      <= '0;
                ph_q       <= '0;
                sclk_q     <= 1'b0;
                cs_n_q     <= 1'b0;
                tx_q       <= 8'hFF;
                addr_q     <= block_addr_i;
                error_q    <= 1'b0;
                err_code_q <= 2'd0;
            end else if (run_q) begin
                cnt_q <= tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    ph_q <= ph_q + 4'd1;
                    if (!ph_q[0]) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[5:0], miso_i};
                    end else begin
                        sclk_q <= 1'b0;
                        if (ph_q == 4'd15) begin
                            tx_q   <= tx_next;
                            cs_n_q <= (state_q == S_TAIL);
                            run_q  <= !fin;
                        end else begin
                            tx_q <= {tx_q[6:0], 1'b1};
                        end
                    end
                end
                if (dv_set) begin
                    data_valid_q <= 1'b1;
                    data_out_q   <= rx_byte;
                end
                if (crc_hi_we) begin
                    crc_q[15:8] <= rx_byte;
                end
                if (crc_lo_we) begin
                    crc_q[7:0] <= rx_byte;
                end
                if (abort) begin
                    error_q    <= 1'b1;
                    err_code_q <= abort_code;
                end
            end
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign err_code_o   = err_code_q;
    assign data_out_o   = data_out_q;
    assign data_valid_o = data_valid_q;
    assign crc_out_o    = crc_q;
    assign sclk_o       = sclk_q;
    assign cs_n_o       = cs_n_q;
    assign mosi_o       = tx_q[7];

endmodule
